// File: rtl/rc4_phase_sequencer.sv
// Top-level RC4 phase controller: sequences init -> KSA -> PRGA engines,
// owns the shared S-RAM port and guards each phase with a saturating watchdog.
module rc4_phase_sequencer #(
   parameter int TIMEOUT = 4096,
   parameter int CNT_W   = 13
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       clear_err,
   output logic       init_start,
   output logic       ksa_start,
   output logic       prga_start,
   input  logic       init_done,
   input  logic       ksa_done,
   input  logic       prga_done,
   input  logic [7:0] init_addr,
   input  logic [7:0] ksa_addr,
   input  logic [7:0] prga_addr,
   input  logic [7:0] init_data,
   input  logic [7:0] ksa_data,
   input  logic [7:0] prga_data,
   input  logic       init_wren,
   input  logic       ksa_wren,
   input  logic       prga_wren,
   output logic [7:0] s_address,
   output logic [7:0] s_data,
   output logic       s_wren,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] phase
);

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_INIT_START = 4'd1;
   localparam logic [3:0] S_INIT_RUN   = 4'd2;
   localparam logic [3:0] S_KSA_START  = 4'd3;
   localparam logic [3:0] S_KSA_RUN    = 4'd4;
   localparam logic [3:0] S_PRGA_START = 4'd5;
   localparam logic [3:0] S_PRGA_RUN   = 4'd6;
   localparam logic [3:0] S_DONE       = 4'd7;
   localparam logic [3:0] S_ERROR      = 4'd8;

   logic [3:0]       r_state;
   logic [3:0]       w_next;
   logic [CNT_W-1:0] r_wdog;
   logic [1:0]       r_phase;
   logic             r_init_start;
   logic             r_ksa_start;
   logic             r_prga_start;
   logic             w_timeout;
   logic             w_in_start;
   logic             w_in_run;

   assign w_timeout  = (r_wdog >= CNT_W'(TIMEOUT));
   assign w_in_start = (r_state == S_INIT_START) || (r_state == S_KSA_START) ||
                       (r_state == S_PRGA_START);
   assign w_in_run   = (r_state == S_INIT_RUN) || (r_state == S_KSA_RUN) ||
                       (r_state == S_PRGA_RUN);

   // A done pulse is checked before the watchdog, so a completion on the
   // timeout cycle still advances the sequence.
   always_comb begin
      // NOTE: default first so every path assigns w_next and no latch is inferred.
      w_next = r_state;
      case (r_state)
         S_IDLE:       if (start) w_next = S_INIT_START;
         S_INIT_START: w_next = S_INIT_RUN;
         S_INIT_RUN:   if (init_done) w_next = S_KSA_START;
                       else if (w_timeout) w_next = S_ERROR;
         S_KSA_START:  w_next = S_KSA_RUN;
         S_KSA_RUN:    if (ksa_done) w_next = S_PRGA_START;
                       else if (w_timeout) w_next = S_ERROR;
         S_PRGA_START: w_next = S_PRGA_RUN;
         S_PRGA_RUN:   if (prga_done) w_next = S_DONE;
                       else if (w_timeout) w_next = S_ERROR;
         S_DONE:       if (start) w_next = S_INIT_START;
         S_ERROR:      if (clear_err) w_next = S_IDLE;
         default:      w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_wdog       <= '0;
         r_phase      <= 2'd0;
         r_init_start <= 1'b0;
         r_ksa_start  <= 1'b0;
         r_prga_start <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         r_state      <= w_next;
         r_init_start <= (w_next == S_INIT_START);
         r_ksa_start  <= (w_next == S_KSA_START);
         r_prga_start <= (w_next == S_PRGA_START);
         if (w_in_start)
            r_wdog <= '0;
         else if (w_in_run && (r_wdog != {CNT_W{1'b1}}))
            r_wdog <= r_wdog + CNT_W'(1);
         case (w_next)
            S_IDLE:       r_phase <= 2'd0;
            S_INIT_START: r_phase <= 2'd1;
            S_KSA_START:  r_phase <= 2'd2;
            S_PRGA_START: r_phase <= 2'd3;
            default:      ;
         endcase
      end
   end

   // Write enable is only passed in RUN; decoding from r_state makes it drop
   // the instant reset is asserted.
   always_comb begin
      s_address = 8'd0;
      s_data    = 8'd0;
      s_wren    = 1'b0;
      case (r_state)
         S_INIT_START, S_INIT_RUN: begin
            s_address = init_addr;
            s_data    = init_data;
            s_wren    = (r_state == S_INIT_RUN) && init_wren;
         end
         S_KSA_START, S_KSA_RUN: begin
            s_address = ksa_addr;
            s_data    = ksa_data;
            s_wren    = (r_state == S_KSA_RUN) && ksa_wren;
         end
         S_PRGA_START, S_PRGA_RUN: begin
            s_address = prga_addr;
            s_data    = prga_data;
            s_wren    = (r_state == S_PRGA_RUN) && prga_wren;
         end
         default: ;
      endcase
   end

   assign init_start = r_init_start;
   assign ksa_start  = r_ksa_start;
   assign prga_start = r_prga_start;
   assign busy       = w_in_start || w_in_run;
   assign done       = (r_state == S_DONE);
   assign error      = (r_state == S_ERROR);
   assign phase      = r_phase;

endmodule

// File: doc/rc4_phase_sequencer.md
Name: rc4_phase_sequencer

Overview:
- Top-level controller for the RC4 decryptor. On `start`, it runs the three S-memory engines in order: init (s[i]=i), KSA (key schedule swaps), then PRGA (keystream/decrypt). Each engine is launched with a one-cycle `start` pulse and reports completion with a one-cycle `done` pulse.
- Owns the single 256x8 S-RAM port and muxes the active engine's address/data/wren onto it.
- Watchdog per phase: a stalled engine drives the block to a sticky ERROR state.

Parameters:
- TIMEOUT, 4096, max cycles a phase may stay in RUN before ERROR (must be >= 1).
- CNT_W, 13, watchdog counter width; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin full init→KSA→PRGA sequence; honoured only in IDLE or DONE.
- clear_err  in  1  leave ERROR for IDLE.
- init_start / ksa_start / prga_start  out  1 each  one-cycle launch pulse to engine.
- init_done / ksa_done / prga_done  in  1 each  one-cycle completion pulse from engine.
- init_addr / ksa_addr / prga_addr  in  8 each  engine S-RAM address.
- init_data / ksa_data / prga_data  in  8 each  engine S-RAM write data.
- init_wren / ksa_wren / prga_wren  in  1 each  engine S-RAM write enable.
- s_address  out  8  to S-RAM.
- s_data  out  8  to S-RAM.
- s_wren  out  1  to S-RAM.
- busy  out  1  high in any *_START or *_RUN state.
- done  out  1  high in DONE.
- error  out  1  high in ERROR.
- phase  out  2  0=none, 1=init, 2=KSA, 3=PRGA (active or last-failed phase).

Behaviour:
- States: IDLE, INIT_START, INIT_RUN, KSA_START, KSA_RUN, PRGA_START, PRGA_RUN, DONE, ERROR.
- Reset (rst_n=0, async): state=IDLE, all *_start=0, s_address=0, s_data=0, s_wren=0, busy=0, done=0, error=0, phase=0, watchdog=0.
- Transitions:
  - IDLE --start--> INIT_START.
  - X_START → X_RUN unconditionally after 1 cycle. The matching x_start output is high for exactly that one cycle; the start outputs are registered.
  - X_RUN --x_done--> next X_START (INIT→KSA→PRGA); PRGA_RUN --prga_done--> DONE.
  - X_RUN with watchdog==TIMEOUT and no x_done → ERROR.
  - DONE --start--> INIT_START; otherwise DONE holds.
  - ERROR --clear_err--> IDLE; start is ignored in ERROR.
- Latency: start high at edge N → init_start high during cycle N+1. An engine done at edge M → next engine's start high during cycle M+1. prga_done at edge M → done=1 from M+1.
- Watchdog: cleared to 0 on entry to any X_RUN; increments each RUN cycle; saturates (never wraps).
- Boundary cases:
  - x_done in the same cycle the watchdog reaches TIMEOUT: done wins, no error.
  - Done pulses from a non-active engine, or during X_START, are ignored.
- Memory mux:
  - s_address/s_data follow the active engine's addr/data combinationally in X_START and X_RUN.
  - s_wren = x_wren only in X_RUN; it is forced 0 in all other states, including X_START.
  - In IDLE/DONE/ERROR: s_address=0, s_data=0, s_wren=0.
- start is ignored while busy; re-assertion mid-sequence has no effect.
- phase: set on entry to X_START; held in DONE (=3) and ERROR (phase that timed out); 0 in IDLE.
- rst_n asserted mid-phase returns to IDLE immediately. s_wren drops asynchronously, so no partial write is issued after reset assertion.

Test Plan:
- Normal run: pulse start; engine models assert done after 258 / 768 / 1000 RUN cycles → exactly one start pulse per engine, in order; done=1; phase=3; busy=0.
- Mux check: init model writes addr=i, data=i for i=0..255 in INIT_RUN → RAM model holds s[i]=i; no writes are seen while in KSA_START or in IDLE.
- Watchdog: TIMEOUT=16, ksa model never asserts done → error=1 after 17 KSA_RUN cycles; phase=2; s_wren=0; start ignored; clear_err → IDLE with phase=0.
- Race: TIMEOUT=16, init_done asserted on the cycle watchdog==16 → KSA_START is entered, error stays 0.
- Spurious inputs: prga_done pulsed during INIT_RUN, and start pulsed during KSA_RUN → no state change, no extra start pulses.
- Reset mid-PRGA: rst_n low for 1 cycle → all outputs are reset values immediately; a fresh start then reruns the full sequence from init.
